// File: rtl/display_scan_decoder.sv
// Receive side of the 4-digit multiplexed 7-segment bus: de-ghosts, decodes and reassembles the 16-bit value.
// Optional DP capture is enabled by defining DP_CAPTURE_EN; otherwise puntos is tied to 4'b0000.
module display_scan_decoder #(
  parameter int ESTABLE = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  prenderDisplay,
  input  logic [6:0]  ledsAhastaG,
  input  logic        DP,
  output logic [15:0] valor,
  output logic [3:0]  puntos,
  output logic        frame_listo,
  output logic        error_segmento,
  output logic        error_anodo,
  output logic        sin_senal
);

  localparam int CW = $clog2(ESTABLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] EST_C     = CW'(ESTABLE);
  localparam logic [TW-1:0] TMO_C     = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_ULT_C = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ESPERA, EVALUAR, RETENIDO} estado_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } muestra_t;

  muestra_t          raw, s, held;
  logic [CW-1:0]     cnt;
  estado_t           estado, estado_sig;
  logic [3:0]        mask;
  logic [3:0][3:0]   shadow_val;
  logic [TW-1:0]     tmo;
  logic              commit_ok, commit_bad, anodo_mal;
  logic [1:0]        pos;
  logic [4:0]        dec;

  // With DP capture off the pin is forced inactive so it never disturbs the stability compare.
  always_comb begin
    raw.an  = prenderDisplay;
    raw.seg = ledsAhastaG;
`ifdef DP_CAPTURE_EN
    raw.dp  = DP;
`else
    raw.dp  = 1'b1;
`endif
  end

`ifndef DP_CAPTURE_EN
  logic dp_unused;
  assign dp_unused = DP;
`endif

  // Inverse of the team segment encoder: {valid, nibble}.
  function automatic logic [4:0] decodificar(input logic [6:0] seg);
    case (seg)
      7'b0000001: decodificar = 5'h10;
      7'b1001111: decodificar = 5'h11;
      7'b0010010: decodificar = 5'h12;
      7'b0000110: decodificar = 5'h13;
      7'b1001100: decodificar = 5'h14;
      7'b0100100: decodificar = 5'h15;
      7'b0100000: decodificar = 5'h16;
      7'b0001101: decodificar = 5'h17;
      7'b0000000: decodificar = 5'h18;
      7'b0000100: decodificar = 5'h19;
      7'b0001000: decodificar = 5'h1A;
      7'b1100000: decodificar = 5'h1B;
      7'b0110001: decodificar = 5'h1C;
      7'b1000010: decodificar = 5'h1D;
      7'b0110000: decodificar = 5'h1E;
      7'b0111000: decodificar = 5'h1F;
      default:    decodificar = 5'h00;
    endcase
  endfunction

  // cnt is the age of the current sample s, so it reloads when the incoming sample differs.
  // NOTE: every sequential assignment uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s   <= '1;
      cnt <= '0;
    end else begin
      s <= raw;
      if (raw != s)
        cnt <= CW'(1);
      else if (cnt < EST_C)
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= ESPERA;
      held   <= '1;
    end else begin
      estado <= estado_sig;
      if (estado == ESPERA && cnt == EST_C)
        held <= s;
    end
  end

  // NOTE: each always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    estado_sig = estado;
    case (estado)
      ESPERA:   if (cnt == EST_C) estado_sig = EVALUAR;
      EVALUAR:  estado_sig = RETENIDO;
      RETENIDO: if (s != held) estado_sig = ESPERA;
      default:  estado_sig = ESPERA;
    endcase
  end

  always_comb begin
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    anodo_mal  = 1'b0;
    pos        = 2'd0;
    dec        = decodificar(held.seg);
    if (estado == EVALUAR) begin
      case (held.an)
        4'b1110: pos = 2'd0;
        4'b1101: pos = 2'd1;
        4'b1011: pos = 2'd2;
        4'b0111: pos = 2'd3;
        4'b1111: ;
        default: anodo_mal = 1'b1;
      endcase
      if (held.an != 4'b1111 && !anodo_mal) begin
        commit_ok  = dec[4];
        commit_bad = !dec[4];
      end
    end
  end

  // NOTE: the shadow slots carry no reset; the mask guarantees a slot is rewritten before it is published.
  always_ff @(posedge clk) begin
    if (commit_ok)
      shadow_val[pos] <= dec[3:0];
  end

`ifdef DP_CAPTURE_EN
  logic [3:0] shadow_dp;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_dp <= '0;
      puntos    <= '0;
    end else begin
      if (commit_ok)
        shadow_dp[pos] <= ~held.dp;
      if (mask == 4'b1111)
        puntos <= shadow_dp;
    end
  end
`else
  assign puntos = 4'b0000;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mask           <= '0;
      valor          <= '0;
      frame_listo    <= 1'b0;
      error_segmento <= 1'b0;
      error_anodo    <= 1'b0;
      tmo            <= '0;
      sin_senal      <= 1'b0;
    end else begin
      frame_listo <= 1'b0;
      if (mask == 4'b1111) begin
        valor       <= shadow_val;
        frame_listo <= 1'b1;
        mask        <= '0;
      end
      if (commit_ok)
        mask[pos] <= 1'b1;
      if (commit_bad) begin
        error_segmento <= 1'b1;
        mask           <= '0;
      end
      if (anodo_mal)
        error_anodo <= 1'b1;

      // A dead bus drops any partial frame but keeps the last published value.
      if (commit_ok) begin
        tmo       <= '0;
        sin_senal <= 1'b0;
      end else if (tmo == TMO_C) begin
        mask <= '0;
      end else if (tmo == TMO_ULT_C) begin
        tmo       <= TMO_C;
        sin_senal <= 1'b1;
        mask      <= '0;
      end else begin
        tmo <= tmo + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_decoder.sv
// Scoreboard bench for display_scan_decoder: expected frames are queued as scans are driven, popped on frame_listo.
module tb_display_scan_decoder;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  prenderDisplay;
  logic [6:0]  ledsAhastaG;
  logic        DP;
  logic [15:0] valor;
  logic [3:0]  puntos;
  logic        frame_listo;
  logic        error_segmento;
  logic        error_anodo;
  logic        sin_senal;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  p;
  } frame_t;

  frame_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int frames   = 0;

  display_scan_decoder #(.ESTABLE(4), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .prenderDisplay (prenderDisplay),
    .ledsAhastaG    (ledsAhastaG),
    .DP             (DP),
    .valor          (valor),
    .puntos         (puntos),
    .frame_listo    (frame_listo),
    .error_segmento (error_segmento),
    .error_anodo    (error_anodo),
    .sin_senal      (sin_senal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b0000001;  4'h1: enc = 7'b1001111;
      4'h2: enc = 7'b0010010;  4'h3: enc = 7'b0000110;
      4'h4: enc = 7'b1001100;  4'h5: enc = 7'b0100100;
      4'h6: enc = 7'b0100000;  4'h7: enc = 7'b0001101;
      4'h8: enc = 7'b0000000;  4'h9: enc = 7'b0000100;
      4'hA: enc = 7'b0001000;  4'hB: enc = 7'b1100000;
      4'hC: enc = 7'b0110001;  4'hD: enc = 7'b1000010;
      4'hE: enc = 7'b0110000;  default: enc = 7'b0111000;
    endcase
  endfunction

  function automatic logic [3:0] exp_puntos(input logic [3:0] lit);
`ifdef DP_CAPTURE_EN
    exp_puntos = lit;
`else
    exp_puntos = 4'b0000 & lit;
`endif
  endfunction

  function automatic logic [3:0] anodo(input int i);
    logic [3:0] one;
    one = 4'b0001;
    anodo = ~(one << i);
  endfunction

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
    prenderDisplay = an;
    ledsAhastaG    = seg;
    DP             = dp;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives digits 0..n_dig-1 of v; ghost > 0 inserts that many cycles of a bad pattern before each later digit.
  task automatic scan(input logic [15:0] v, input logic [3:0] lit, input int n_dig, input int ghost);
    for (int i = 0; i < n_dig; i++) begin
      if (ghost > 0 && i > 0)
        dwell(anodo(i), 7'b1111110, 1'b1, ghost);
      dwell(anodo(i), enc(v[4*i +: 4]), ~lit[i], 64);
    end
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] lit);
    frame_t f;
    f.v = v;
    f.p = exp_puntos(lit);
    q.push_back(f);
  endtask

  always @(negedge clk) begin
    if (!rst && frame_listo) begin
      frames++;
      if (q.size() == 0) begin
        check("frame_unexpected", 32'(valor), 32'hFFFF_FFFF);
      end else begin
        frame_t e;
        e = q.pop_front();
        check("valor", 32'(valor), 32'(e.v));
        check("puntos", 32'(puntos), 32'(e.p));
      end
    end
  end

  initial begin
    rst = 1'b1;
    prenderDisplay = 4'hF;
    ledsAhastaG    = 7'h7F;
    DP             = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valor", 32'(valor), 32'h0);
    check("rst_puntos", 32'(puntos), 32'h0);
    check("rst_frame_listo", 32'(frame_listo), 32'h0);
    check("rst_err_seg", 32'(error_segmento), 32'h0);
    check("rst_err_an", 32'(error_anodo), 32'h0);
    check("rst_sin_senal", 32'(sin_senal), 32'h0);
    rst = 1'b0;

    // Plain scan 1234
    push(16'h1234, 4'b0000);
    scan(16'h1234, 4'b0000, 4, 0);
    check("scan1_pending", 32'(q.size()), 32'h0);
    check("scan1_frames", 32'(frames), 32'd1);
    check("scan1_err_seg", 32'(error_segmento), 32'h0);
    check("scan1_err_an", 32'(error_anodo), 32'h0);

    // Short ghost patterns between dwells must be filtered
    push(16'hDCBA, 4'b0000);
    scan(16'hDCBA, 4'b0000, 4, 2);
    check("ghost_pending", 32'(q.size()), 32'h0);
    check("ghost_frames", 32'(frames), 32'd2);
    check("ghost_err_seg", 32'(error_segmento), 32'h0);

    // Held invalid pattern on display 2 discards the frame
    dwell(anodo(0), enc(4'hA), 1'b1, 64);
    dwell(anodo(1), enc(4'h5), 1'b1, 64);
    dwell(anodo(2), 7'b1111110, 1'b1, 10);
    check("inval_err_seg", 32'(error_segmento), 32'h1);
    check("inval_frames", 32'(frames), 32'd2);
    check("inval_valor", 32'(valor), 32'hDCBA);
    push(16'h5A5A, 4'b0000);
    scan(16'h5A5A, 4'b0000, 4, 0);
    check("clean_pending", 32'(q.size()), 32'h0);
    check("clean_frames", 32'(frames), 32'd3);

    // Two anodes low: error, no commit, partial frame survives
    push(16'h9876, 4'b0000);
    dwell(anodo(0), enc(4'h6), 1'b1, 64);
    dwell(4'b1100, enc(4'h8), 1'b1, 10);
    check("anode_err", 32'(error_anodo), 32'h1);
    check("anode_valor", 32'(valor), 32'h5A5A);
    check("anode_frames", 32'(frames), 32'd3);
    dwell(anodo(1), enc(4'h7), 1'b1, 64);
    dwell(anodo(2), enc(4'h8), 1'b1, 64);
    dwell(anodo(3), enc(4'h9), 1'b1, 64);
    check("anode_pending", 32'(q.size()), 32'h0);
    check("anode_frames2", 32'(frames), 32'd4);

    // Dead bus: roughly 58 idle counts already elapsed after the last commit
    dwell(4'hF, 7'h7F, 1'b1, TMO - 100);
    check("tmo_before", 32'(sin_senal), 32'h0);
    dwell(4'hF, 7'h7F, 1'b1, 110);
    check("tmo_after", 32'(sin_senal), 32'h1);
    check("tmo_valor", 32'(valor), 32'h9876);
    dwell(anodo(0), enc(4'h3), 1'b1, 64);
    check("tmo_recover", 32'(sin_senal), 32'h0);

    // Reset mid-frame, then a fresh scan must carry no stale nibbles
    scan(16'hFFFF, 4'b1111, 3, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_valor", 32'(valor), 32'h0);
    check("rst2_err_seg", 32'(error_segmento), 32'h0);
    check("rst2_err_an", 32'(error_anodo), 32'h0);
    check("rst2_sin_senal", 32'(sin_senal), 32'h0);
    rst = 1'b0;
    check("rst2_frames", 32'(frames), 32'd4);
    push(16'h0007, 4'b0001);
    scan(16'h0007, 4'b0001, 4, 0);
    check("final_pending", 32'(q.size()), 32'h0);
    check("final_frames", 32'(frames), 32'd5);

    dwell(4'hF, 7'h7F, 1'b1, 10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
